// File: rtl/run_sequencer.sv
// Run-control sequencer: DDR reset, settle, event-path reset, open wait,
// running, drain, with sticky error handling and a completed-run counter.
module run_sequencer #(
    parameter int unsigned DDR_RST_CYCLES  = 16,
    parameter int unsigned DDR_WAIT_CYCLES = 64,
    parameter int unsigned OPEN_TIMEOUT    = 1024,
    parameter int unsigned DRAIN_TIMEOUT   = 4096
) (
    input  logic        wb_clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_err_i,
    input  logic        event_open_i,
    input  logic        pending_i,
    output logic        ddr_reset_o,
    output logic        event_force_reset_o,
    output logic        trigger_running_o,
    output logic        seq_err_o,
    output logic [2:0]  state_o,
    output logic [15:0] run_count_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DDR_RST   = 3'd1,
        S_DDR_WAIT  = 3'd2,
        S_EVT_RST   = 3'd3,
        S_OPEN_WAIT = 3'd4,
        S_RUNNING   = 3'd5,
        S_DRAIN     = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam logic [15:0] DDR_RST_LOAD  = 16'(DDR_RST_CYCLES - 1);
    localparam logic [15:0] DDR_WAIT_LOAD = 16'(DDR_WAIT_CYCLES - 1);
    localparam logic [15:0] EVT_RST_LOAD  = 16'd3;
    localparam logic [15:0] OPEN_LOAD     = 16'(OPEN_TIMEOUT - 1);
    localparam logic [15:0] DRAIN_LOAD    = 16'(DRAIN_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] run_count_q, run_count_d;
    logic        ddr_reset_q, ddr_reset_d;
    logic        evt_rst_q, evt_rst_d;
    logic        trig_q, trig_d;
    logic        err_q, err_d;
    logic        expired;

    // Counter holds "cycles remaining minus one", so zero means this is the last cycle.
    function automatic logic [15:0] load_value(input state_t s);
        case (s)
            S_DDR_RST:   load_value = DDR_RST_LOAD;
            S_DDR_WAIT:  load_value = DDR_WAIT_LOAD;
            S_EVT_RST:   load_value = EVT_RST_LOAD;
            S_OPEN_WAIT: load_value = OPEN_LOAD;
            S_DRAIN:     load_value = DRAIN_LOAD;
            default:     load_value = 16'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        run_count_d = run_count_q;
        expired     = (cnt_q == 16'd0);
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) state_d = S_DDR_RST;
            end
            S_DDR_RST: begin
                if (stop_i)       state_d = S_IDLE;
                else if (expired) state_d = S_DDR_WAIT;
            end
            S_DDR_WAIT: begin
                if (stop_i)       state_d = S_IDLE;
                else if (expired) state_d = S_EVT_RST;
            end
            S_EVT_RST: begin
                if (stop_i)       state_d = S_IDLE;
                else if (expired) state_d = S_OPEN_WAIT;
            end
            S_OPEN_WAIT: begin
                if (stop_i)            state_d = S_IDLE;
                else if (event_open_i) state_d = S_RUNNING;
                else if (expired)      state_d = S_ERROR;
            end
            S_RUNNING: begin
                // Losing the event path outranks a simultaneous stop.
                if (!event_open_i) state_d = S_ERROR;
                else if (stop_i)   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pending_i) begin
                    state_d     = S_IDLE;
                    run_count_d = run_count_q + 16'd1;
                end else if (expired) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (clear_err_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)  cnt_d = load_value(state_d);
        else if (!expired)       cnt_d = cnt_q - 16'd1;
        else                     cnt_d = cnt_q;

        // Outputs decode the next state so they flip on the same edge as state.
        ddr_reset_d = (state_d == S_DDR_RST);
        evt_rst_d   = (state_d == S_EVT_RST) || (state_d == S_ERROR);
        trig_d      = (state_d == S_RUNNING);
        err_d       = (state_d == S_ERROR);
    end

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            run_count_q <= 16'd0;
            ddr_reset_q <= 1'b0;
            evt_rst_q   <= 1'b0;
            trig_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_count_q <= run_count_d;
            ddr_reset_q <= ddr_reset_d;
            evt_rst_q   <= evt_rst_d;
            trig_q      <= trig_d;
            err_q       <= err_d;
        end
    end

    assign ddr_reset_o         = ddr_reset_q;
    assign event_force_reset_o = evt_rst_q;
    assign trigger_running_o   = trig_q;
    assign seq_err_o           = err_q;
    assign state_o             = state_q;
    assign run_count_o         = run_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: elapsed-time reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_run_sequencer;

    localparam int DDR_RST_CYCLES  = 16;
    localparam int DDR_WAIT_CYCLES = 64;
    localparam int OPEN_TIMEOUT    = 1024;
    localparam int DRAIN_TIMEOUT   = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear_err = 1'b0;
    logic        event_open = 1'b0, pending = 1'b0;
    logic        ddr_reset, evt_rst, trig, seq_err;
    logic [2:0]  state;
    logic [15:0] run_count;

    int errors = 0;
    int checks = 0;
    logic cmp_en   = 1'b0;
    logic skip_cnt = 1'b0;
    logic preload  = 1'b0;

    run_sequencer #(
        .DDR_RST_CYCLES (DDR_RST_CYCLES),
        .DDR_WAIT_CYCLES(DDR_WAIT_CYCLES),
        .OPEN_TIMEOUT   (OPEN_TIMEOUT),
        .DRAIN_TIMEOUT  (DRAIN_TIMEOUT)
    ) dut (
        .wb_clk_i           (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .stop_i             (stop),
        .clear_err_i        (clear_err),
        .event_open_i       (event_open),
        .pending_i          (pending),
        .ddr_reset_o        (ddr_reset),
        .event_force_reset_o(evt_rst),
        .trigger_running_o  (trig),
        .seq_err_o          (seq_err),
        .state_o            (state),
        .run_count_o        (run_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus cycles elapsed since entering it.
    int        m_phase = 0;
    int        m_age   = 0;
    logic [15:0] m_runs = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        int nxt;
        if (!rst_n) begin
            m_phase = 0;
            m_age   = 0;
            m_runs  = 16'd0;
        end else begin
            if (preload) m_runs = 16'hFFFF;
            nxt = m_phase;
            case (m_phase)
                0: if (start && !stop) nxt = 1;
                1: if (stop) nxt = 0; else if (m_age + 1 >= DDR_RST_CYCLES) nxt = 2;
                2: if (stop) nxt = 0; else if (m_age + 1 >= DDR_WAIT_CYCLES) nxt = 3;
                3: if (stop) nxt = 0; else if (m_age + 1 >= 4) nxt = 4;
                4: if (stop) nxt = 0; else if (event_open) nxt = 5;
                   else if (m_age + 1 >= OPEN_TIMEOUT) nxt = 7;
                5: if (!event_open) nxt = 7; else if (stop) nxt = 6;
                6: if (!pending) begin nxt = 0; m_runs = m_runs + 16'd1; end
                   else if (m_age + 1 >= DRAIN_TIMEOUT) nxt = 7;
                7: if (clear_err) nxt = 0;
                default: nxt = 0;
            endcase
            if (nxt != m_phase) m_age = 0;
            else                m_age = m_age + 1;
            m_phase = nxt;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                logic e_ddr, e_evt, e_trig, e_err;
                e_ddr  = (m_phase == 1);
                e_evt  = (m_phase == 3) || (m_phase == 7);
                e_trig = (m_phase == 5);
                e_err  = (m_phase == 7);
                checks++;
                if (state != 3'(m_phase) || ddr_reset != e_ddr || evt_rst != e_evt ||
                    trig != e_trig || seq_err != e_err ||
                    (!skip_cnt && run_count != m_runs)) begin
                    errors++;
                    $display("FAIL model t=%0t state=%0d/%0d ddr=%b/%b evt=%b/%b trig=%b/%b err=%b/%b cnt=%h/%h (actual/required)",
                             $time, state, m_phase, ddr_reset, e_ddr, evt_rst, e_evt,
                             trig, e_trig, seq_err, e_err, run_count, m_runs);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        int n = 0;
        while (int'(state) != s && n < limit) begin
            step();
            n++;
        end
        if (int'(state) != s) check({name, "_timeout"}, int'(state), s);
    endtask

    // sel: 0 ddr_reset high, 1 all outputs low, 2 evt_rst high, 3 in OPEN_WAIT, 4 in DRAIN
    task automatic count_while(input int sel, output int n);
        logic c;
        n = 0;
        forever begin
            case (sel)
                0: c = ddr_reset;
                1: c = !ddr_reset && !evt_rst && !trig && !seq_err;
                2: c = evt_rst;
                3: c = (state == 3'd4);
                default: c = (state == 3'd6);
            endcase
            if (!c || n >= 10000) break;
            n++;
            step();
        end
    endtask

    task automatic get_to_running();
        event_open = 1'b1;
        pending    = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_state(5, 200, "reach_running");
    endtask

    task automatic clear_error();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        check("reset_state", state, 0);
        check("reset_outputs", {ddr_reset, evt_rst, trig, seq_err}, 0);
        check("reset_count", run_count, 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        step();

        // Full run
        event_open = 1'b1;
        pending    = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        count_while(0, n);  check("ddr_reset_len", n, 16);
        count_while(1, n);  check("ddr_wait_len", n, 64);
        count_while(2, n);  check("evt_rst_len", n, 4);
        check("open_wait_state", state, 4);
        step();
        check("running_trig", trig, 1);
        repeat (99) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("drain_state", state, 6);
        step();
        check("run_idle", state, 0);
        check("run_count_1", run_count, 1);

        // Open timeout
        event_open = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_state(4, 200, "reach_open_wait");
        count_while(3, n);  check("open_timeout_len", n, 1024);
        check("open_timeout_err", state, 7);
        check("open_timeout_seq_err", seq_err, 1);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("error_ignores_start_stop", state, 7);
        clear_error();
        check("clear_idle", state, 0);
        check("clear_seq_err", seq_err, 0);

        // Drain timeout
        get_to_running();
        stop    = 1'b1;
        pending = 1'b1;
        step();
        stop = 1'b0;
        count_while(4, n);  check("drain_timeout_len", n, 4096);
        check("drain_timeout_err", state, 7);
        check("drain_timeout_count", run_count, 1);
        pending = 1'b0;
        clear_error();

        // Abort in DDR_RST cycle 5
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("abort_pre", state, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("abort_idle", state, 0);
        check("abort_ddr_low", ddr_reset, 0);
        check("abort_count", run_count, 1);

        // Simultaneous events
        get_to_running();
        stop       = 1'b1;
        event_open = 1'b0;
        step();
        stop = 1'b0;
        check("stop_and_close_err", state, 7);
        clear_error();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", state, 0);
        step();
        check("start_stop_idle2", state, 0);

        // Reset in RUNNING
        get_to_running();
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {ddr_reset, evt_rst, trig, seq_err}, 0);
        check("rst_state", state, 0);
        check("rst_count", run_count, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", state, 0);

        // Counter wrap
        force dut.run_count_q = 16'hFFFF;
        preload  = 1'b1;
        skip_cnt = 1'b1;
        step();
        release dut.run_count_q;
        preload  = 1'b0;
        skip_cnt = 1'b0;
        check("preload_count", run_count, 16'hFFFF);
        get_to_running();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_state(0, 20, "wrap_idle");
        check("wrap_count", run_count, 0);

        // Randomized phase
        event_open = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            start     = ($urandom % 16) == 0;
            stop      = ($urandom % 32) == 0;
            clear_err = ($urandom % 8) == 0;
            pending   = ($urandom % 4) != 0;
            if (($urandom % 64) == 0) event_open = ~event_open;
            rst_n     = ($urandom % 2000) != 0;
            step();
        end
        rst_n = 1'b1;
        start = 1'b0; stop = 1'b0; clear_err = 1'b0;
        step();
        step();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
